alu_seq: RTL and testbench

Registered, parametrised-width ALU for the LEGv8 datapath with valid/ready handshakes on input and output. Single-cycle operations return one cycle after acceptance. An optional iterative multiplier takes WIDTH cycles. The block produces N/Z/C/V flags for flag-setting instructions and CBZ/B.cond, and sits between the register-file read stage and the writeback/flag registers.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake and data bundle between the operand producer, the alu_seq block and the result consumer.
interface alu_seq_if #(
  parameter int WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       opt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ans;
  logic [3:0]       flags;
  logic             illegal;

  modport master (
    output in_valid, A, B, opt, out_ready,
    input  in_ready, out_valid, ans, flags, illegal
  );

  modport slave (
    input  in_valid, A, B, opt, out_ready,
    output in_ready, out_valid, ans, flags, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Registered LEGv8 ALU with valid/ready handshakes and {N,Z,C,V} flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 1001, WIDTH cycles).
module alu_seq #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic   clk,
  input logic   rst,
  alu_seq_if.slave bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1001;
  typedef enum logic {IDLE, BUSY} state_t;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t state_reg, state_next;

  logic             out_valid_reg;
  logic [WIDTH-1:0] ans_reg;
  logic [3:0]       flags_reg;
  logic             illegal_reg;

  logic             in_ready_c;
  logic             load_out;
  logic [WIDTH-1:0] load_ans;
  logic [3:0]       load_flags;
  logic             load_illegal;

  logic [WIDTH-1:0] alu_ans;
  logic             alu_c;
  logic             alu_v;
  logic             alu_illegal;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             is_mul;

  // Single-cycle datapath, evaluated on the live inputs; only used on the accept edge.
  always_comb begin
    alu_ans     = '0;
    alu_c       = 1'b0;
    alu_v       = 1'b0;
    alu_illegal = 1'b0;
    is_mul      = 1'b0;
    sum         = {1'b0, bus.A} + {1'b0, bus.B};
    diff        = {1'b0, bus.A} - {1'b0, bus.B};
    case (bus.opt)
      OP_AND:  alu_ans = bus.A & bus.B;
      OP_OR:   alu_ans = bus.A | bus.B;
      OP_NOR:  alu_ans = ~(bus.A | bus.B);
      OP_PASS: alu_ans = bus.B;
      OP_LSL:  alu_ans = bus.A << bus.B[SHW-1:0];
      OP_LSR:  alu_ans = bus.A >> bus.B[SHW-1:0];
      OP_ADD: begin
        alu_ans = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        // The borrow bit of the widened difference is set exactly when A < B unsigned.
        alu_ans = diff[WIDTH-1:0];
        alu_c   = ~diff[WIDTH];
        alu_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
`ifdef ALU_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] prod_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH-1:0] prod_next;
  logic             mul_start;
  logic             mul_step;

  assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
    end else if (mul_start) begin
      mcand_reg  <= bus.A;
      mplier_reg <= bus.B;
      prod_reg   <= '0;
      cnt_reg    <= '0;
    end else if (mul_step) begin
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      prod_reg   <= prod_next;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    in_ready_c   = 1'b0;
    load_out     = 1'b0;
    load_ans     = alu_ans;
    load_flags   = {alu_ans[WIDTH-1], (alu_ans == '0), alu_c, alu_v};
    load_illegal = alu_illegal;
`ifdef ALU_MUL_EN
    mul_start    = 1'b0;
    mul_step     = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        in_ready_c = !out_valid_reg || bus.out_ready;
        if (bus.in_valid && in_ready_c) begin
          if (is_mul) begin
`ifdef ALU_MUL_EN
            mul_start  = 1'b1;
            state_next = BUSY;
`endif
          end else begin
            load_out = 1'b1;
          end
        end
      end
`ifdef ALU_MUL_EN
      BUSY: begin
        if (cnt_reg != SHW'(WIDTH - 1)) begin
          mul_step = 1'b1;
        end else if (!out_valid_reg || bus.out_ready) begin
          // Last step only completes once the output register is free, so a stalled result is never overwritten.
          mul_step     = 1'b1;
          load_out     = 1'b1;
          load_ans     = prod_next;
          load_flags   = {prod_next[WIDTH-1], (prod_next == '0), 1'b0, 1'b0};
          load_illegal = 1'b0;
          state_next   = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      ans_reg       <= '0;
      flags_reg     <= 4'b0100;
      illegal_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_out) begin
        out_valid_reg <= 1'b1;
        ans_reg       <= load_ans;
        flags_reg     <= load_flags;
        illegal_reg   <= load_illegal;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_reg;
  assign bus.ans       = ans_reg;
  assign bus.flags     = flags_reg;
  assign bus.illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=64); follows ALU_MUL_EN for the multiply expectations.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(64)) bus ();

  alu_seq #(.WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] ans;
    logic [3:0]  fl;
    logic        ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] ans, input logic [3:0] fl, input logic ill);
    vecs[i].op  = op;
    vecs[i].a   = a;
    vecs[i].b   = b;
    vecs[i].ans = ans;
    vecs[i].fl  = fl;
    vecs[i].ill = ill;
  endtask

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.in_valid = 1'b1;
    bus.opt      = op;
    bus.A        = a;
    bus.B        = b;
  endtask

  initial begin
    int lat;
    int ir_bad;
    int ov_seen;

    set_vec(0,  4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                  64'h8000_0000_0000_0000, 4'b1001, 1'b0);
    set_vec(1,  4'b0110, 64'h5,                   64'h5,                  64'h0,                   4'b0110, 1'b0);
    set_vec(2,  4'b0110, 64'h3,                   64'h5,                  64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b0);
    set_vec(3,  4'b0011, 64'h1,                   64'h43,                 64'h8,                   4'b0000, 1'b0);
    set_vec(4,  4'b0100, 64'h80,                  64'h4,                  64'h8,                   4'b0000, 1'b0);
    set_vec(5,  4'b0000, 64'hF0F0,                64'hFF00,               64'hF000,                4'b0000, 1'b0);
    set_vec(6,  4'b0001, 64'h0F,                  64'hF0,                 64'hFF,                  4'b0000, 1'b0);
    set_vec(7,  4'b1100, 64'h0,                   64'h0,                  64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0);
    set_vec(8,  4'b0111, 64'h123,                 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'b1000, 1'b0);
    set_vec(9,  4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                  64'h0,                   4'b0110, 1'b0);
    set_vec(10, 4'b1111, 64'h1234,                64'h5678,               64'h0,                   4'b0100, 1'b1);
    set_vec(11, 4'b0101, 64'h1,                   64'h1,                  64'h0,                   4'b0100, 1'b1);
    set_vec(12, 4'b0110, 64'h8000_0000_0000_0000, 64'h1,                  64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1'b0);
    set_vec(13, 4'b0011, 64'h1,                   64'hFFFF_FFFF_FFFF_FF3F, 64'h8000_0000_0000_0000, 4'b1000, 1'b0);

    bus.in_valid  = 1'b0;
    bus.opt       = 4'b0000;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ans",       bus.ans,            64'd0);
    chk("rst_flags",     64'(bus.flags),     64'h4);
    chk("rst_illegal",   64'(bus.illegal),   64'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);

    // Back-to-back single-cycle ops at full rate with the consumer always ready.
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      $display("vec %0d op=%b a=%h b=%h -> ans=%h flags=%b illegal=%b", i, vecs[i].op, vecs[i].a, vecs[i].b,
               bus.ans, bus.flags, bus.illegal);
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("v%0d_ans", i),       bus.ans,            vecs[i].ans);
      chk($sformatf("v%0d_flags", i),     64'(bus.flags),     64'(vecs[i].fl));
      chk($sformatf("v%0d_illegal", i),   64'(bus.illegal),   64'(vecs[i].ill));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);

`ifdef ALU_MUL_EN
    drive(4'b1001, 64'd12345, 64'd678);
    tick();
    bus.in_valid = 1'b0;
    bus.A        = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.B        = 64'h1357_9BDF_2468_ACE0;
    lat    = 0;
    ir_bad = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) ir_bad++;
      tick();
      lat++;
    end
    $display("mul 12345*678 -> ans=%0d latency=%0d", bus.ans, lat);
    chk("mul_latency",     64'(lat),          64'd64);
    chk("mul_in_ready_lo", 64'(ir_bad),       64'd0);
    chk("mul_ans",         bus.ans,           64'd8369910);
    chk("mul_flags",       64'(bus.flags),    64'h0);
    chk("mul_illegal",     64'(bus.illegal),  64'd0);
    chk("mul_in_ready_hi", 64'(bus.in_ready), 64'd1);
    tick();

    drive(4'b1001, 64'd7, 64'd9);
    tick();
    bus.in_valid = 1'b0;
    repeat (30) tick();
    chk("mulrst_busy", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    tick();
    chk("mulrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mulrst_ans",       bus.ans,            64'd0);
    chk("mulrst_flags",     64'(bus.flags),     64'h4);
    rst = 1'b0;
    tick();
    chk("mulrst_idle", 64'(bus.in_ready), 64'd1);
    ov_seen = 0;
    repeat (80) begin
      if (bus.out_valid) ov_seen++;
      tick();
    end
    $display("mul aborted by reset, out_valid seen %0d times", ov_seen);
    chk("mulrst_no_result", 64'(ov_seen), 64'd0);
`else
    drive(4'b1001, 64'd12345, 64'd678);
    tick();
    bus.in_valid = 1'b0;
    $display("mul (compiled out) -> ans=%h illegal=%b", bus.ans, bus.illegal);
    chk("nomul_out_valid", 64'(bus.out_valid), 64'd1);
    chk("nomul_ans",       bus.ans,            64'd0);
    chk("nomul_flags",     64'(bus.flags),     64'h4);
    chk("nomul_illegal",   64'(bus.illegal),   64'd1);
    chk("nomul_in_ready",  64'(bus.in_ready),  64'd1);
    tick();
`endif

    // Backpressure: result held, producer stalled, then drain and accept on one edge.
    bus.out_ready = 1'b0;
    drive(4'b0010, 64'd2, 64'd3);
    tick();
    chk("bp_first_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_first_ans",   bus.ans,            64'd5);
    drive(4'b0010, 64'd10, 64'd20);
    ir_bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.in_ready !== 1'b0 || bus.ans !== 64'd5 || bus.out_valid !== 1'b1) ir_bad++;
      tick();
    end
    $display("backpressure held 5 cycles, ans=%0d", bus.ans);
    chk("bp_hold", 64'(ir_bad), 64'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    $display("backpressure swap -> ans=%0d", bus.ans);
    chk("bp_swap_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_swap_ans",   bus.ans,            64'd30);
    tick();
    chk("bp_drain", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
